k_low_pass_filter_mc: RTL and testbench

Time-multiplexed, multi-channel first-order IIR low-pass filter. It is the parametrised successor of the single-channel k-shift filter in the self-trigger filter chain, and serves N_CH ADC channels through one datapath. Each channel has its own filter state and a runtime-programmable shift k. The block adds valid/channel tagging, bypass, forwarding for back-to-back samples on the same channel, and correct arithmetic (sign-preserving) shifts.

---
 rtl/lpf_mc_pkg.sv | 26 ++
 rtl/lpf_mc_core.sv | 33 +++
 rtl/k_low_pass_filter_mc.sv | 147 ++++++++++++++
 tb/tb_k_low_pass_filter_mc.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpf_mc_pkg.sv
// Shared widths and types for the multi-channel k-shift low-pass filter.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package lpf_mc_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 32;
  localparam int ACC_W  = DATA_W + FRAC_W;
  localparam int K_W    = 6;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic        [K_W-1:0]    k_t;
  typedef logic signed [DATA_W-1:0] data_t;

  typedef struct packed {
    acc_t x_1;
    acc_t y_1;
  } lpf_state_t;

  // A shift of 0 would break the (k-1) term, and anything above FRAC_W
  // throws away the whole fractional field, so only 1..FRAC_W is usable.
  function automatic logic k_legal(input k_t k);
    return (k != '0) && (int'(k) <= FRAC_W);
  endfunction

endpackage

// File: rtl/lpf_mc_core.sv
// One first-order IIR update step: y_new = y_1 + (w3 >>> k) - (y_1 >>> (k-1)).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle on whatever the pipeline presents.
module lpf_mc_core
  import lpf_mc_pkg::*;
(
  input  data_t      data_i,
  input  lpf_state_t st_i,
  input  k_t         k_i,
  output acc_t       w1_o,
  output acc_t       y_new_o
);

  acc_t w3;
  acc_t x_1;
  acc_t y_1;
  acc_t w3_sh;
  acc_t y_sh;
  k_t   k_m1;

  // Sample aligned to the integer field, then the two arithmetic shifts.
  always_comb begin
    x_1     = $signed(st_i.x_1);
    y_1     = $signed(st_i.y_1);
    k_m1    = k_i - k_t'(1);
    w1_o    = {data_i, {FRAC_W{1'b0}}};
    w3      = w1_o + x_1;
    w3_sh   = w3 >>> k_i;
    y_sh    = y_1 >>> k_m1;
    y_new_o = y_1 + w3_sh - y_sh;
  end

endmodule

// File: rtl/k_low_pass_filter_mc.sv
// Time-multiplexed N_CH-channel k-shift IIR low-pass filter with per-channel state and k.
// Latency: 2 cycles from accepted s_valid to m_valid, one sample per clock, any channel order.
// Backpressure: none; enable=0 blocks new captures while the pipeline drains.
module k_low_pass_filter_mc
  import lpf_mc_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int CH_W      = 3,
  parameter int K_DEFAULT = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              s_valid,
  input  logic [CH_W-1:0]   s_ch,
  input  logic [DATA_W-1:0] s_data,
  input  logic              bypass,
  input  logic              k_wr,
  input  logic [CH_W-1:0]   k_wr_ch,
  input  logic [K_W-1:0]    k_wr_val,
  output logic              k_err,
  output logic              m_valid,
  output logic [CH_W-1:0]   m_ch,
  output logic [DATA_W-1:0] m_data
);

  // Per-channel filter state and shift register file.
  lpf_state_t st_q [N_CH];
  k_t         k_q  [N_CH];

  // Stage S1: captured sample with its channel's k and state.
  logic              s1_vld_q,  s1_vld_d;
  logic [CH_W-1:0]   s1_ch_q,   s1_ch_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  k_t                s1_k_q,    s1_k_d;
  logic              s1_byp_q,  s1_byp_d;
  lpf_state_t        s1_st_q,   s1_st_d;

  // Output stage.
  logic              m_vld_q,  m_vld_d;
  logic [CH_W-1:0]   m_ch_q,   m_ch_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              k_err_q,  k_err_d;

  logic       accept;
  logic       fwd;
  logic       k_ok;
  acc_t       w1;
  acc_t       y_new;
  lpf_state_t wr_st;

  lpf_mc_core u_core (
    .data_i  (data_t'(s1_data_q)),
    .st_i    (s1_st_q),
    .k_i     (s1_k_q),
    .w1_o    (w1),
    .y_new_o (y_new)
  );

  // Capture decision, forwarding from S1 on a same-channel back-to-back sample.
  always_comb begin
    accept    = s_valid & enable;
    fwd       = s1_vld_q && (s1_ch_q == s_ch);
    wr_st     = '{x_1: w1, y_1: y_new};
    s1_vld_d  = accept;
    s1_ch_d   = s1_ch_q;
    s1_data_d = s1_data_q;
    s1_k_d    = s1_k_q;
    s1_byp_d  = s1_byp_q;
    s1_st_d   = s1_st_q;
    if (accept) begin
      s1_ch_d   = s_ch;
      s1_data_d = s_data;
      s1_k_d    = k_q[s_ch];
      s1_byp_d  = bypass;
      s1_st_d   = fwd ? wr_st : st_q[s_ch];
    end
  end

  // Output formatting: raw sample on bypass, otherwise floor of the integer field.
  always_comb begin
    m_vld_d  = s1_vld_q;
    m_ch_d   = m_ch_q;
    m_data_d = m_data_q;
    if (s1_vld_q) begin
      m_ch_d   = s1_ch_q;
      m_data_d = s1_byp_q ? s1_data_q : y_new[ACC_W-1:FRAC_W];
    end
  end

  // Sticky flag for any k write outside 1..FRAC_W.
  always_comb begin
    k_ok    = k_legal(k_wr_val);
    k_err_d = k_err_q | (k_wr & ~k_ok);
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_ch_q   <= '0;
      s1_data_q <= '0;
      s1_k_q    <= '0;
      s1_byp_q  <= 1'b0;
      s1_st_q   <= '0;
      m_vld_q   <= 1'b0;
      m_ch_q    <= '0;
      m_data_q  <= '0;
      k_err_q   <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_ch_q   <= s1_ch_d;
      s1_data_q <= s1_data_d;
      s1_k_q    <= s1_k_d;
      s1_byp_q  <= s1_byp_d;
      s1_st_q   <= s1_st_d;
      m_vld_q   <= m_vld_d;
      m_ch_q    <= m_ch_d;
      m_data_q  <= m_data_d;
      k_err_q   <= k_err_d;
    end
  end

  // Filter state write-back; bypassed samples still advance the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) st_q[i] <= '0;
    end else if (s1_vld_q) begin
      st_q[s1_ch_q] <= wr_st;
    end
  end

  // k register file; illegal values leave the old k in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) k_q[i] <= k_t'(K_DEFAULT);
    end else if (k_wr && k_ok) begin
      k_q[k_wr_ch] <= k_wr_val;
    end
  end

  assign m_valid = m_vld_q;
  assign m_ch    = m_ch_q;
  assign m_data  = m_data_q;
  assign k_err   = k_err_q;

endmodule

// File: tb/tb_k_low_pass_filter_mc.sv
// Directed bench for k_low_pass_filter_mc with hand-computed expected outputs.
// Latency: checks every output lands exactly 2 cycles after its input.
// Backpressure: exercises enable=0 drop of new samples.
module tb_k_low_pass_filter_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        s_valid = 1'b0;
  logic [2:0]  s_ch = '0;
  logic [15:0] s_data = '0;
  logic        bypass = 1'b0;
  logic        k_wr = 1'b0;
  logic [2:0]  k_wr_ch = '0;
  logic [5:0]  k_wr_val = '0;
  logic        k_err;
  logic        m_valid;
  logic [2:0]  m_ch;
  logic [15:0] m_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int sq[$];
  int mq_ch[$];
  int mq_dat[$];
  int mq_cyc[$];

  int e0[5] = '{62, 179, 282, 371, 450};
  int e1[5] = '{-63, -180, -283, -372, -451};

  bit o_ok;
  int o_ch, o_dat, o_lat, prev;

  k_low_pass_filter_mc dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_ch     (s_ch),
    .s_data   (s_data),
    .bypass   (bypass),
    .k_wr     (k_wr),
    .k_wr_ch  (k_wr_ch),
    .k_wr_val (k_wr_val),
    .k_err    (k_err),
    .m_valid  (m_valid),
    .m_ch     (m_ch),
    .m_data   (m_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every output beat away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      mq_ch.push_back(int'(m_ch));
      mq_dat.push_back(int'($signed(m_data)));
      mq_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    sq.delete(); mq_ch.delete(); mq_dat.delete(); mq_cyc.delete();
  endtask

  task automatic drive(input logic v, input int ch, input int dat, input logic byp);
    s_valid = v;
    s_ch    = ch[2:0];
    s_data  = dat[15:0];
    bypass  = byp;
    if (v && enable) sq.push_back(cyc);
    @(posedge clk); #1;
    s_valid = 1'b0;
    bypass  = 1'b0;
    k_wr    = 1'b0;
  endtask

  task automatic kwrite(input int ch, input int val);
    k_wr     = 1'b1;
    k_wr_ch  = ch[2:0];
    k_wr_val = val[5:0];
    @(posedge clk); #1;
    k_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    s_valid = 1'b0; k_wr = 1'b0; bypass = 1'b0; enable = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_q();
    reset = 1'b0;
  endtask

  task automatic pop_out(output bit ok, output int ch, output int dat, output int lat);
    int sc;
    ok = (mq_dat.size() > 0);
    ch = -1; dat = 0; lat = -1;
    if (ok) begin
      ch  = mq_ch.pop_front();
      dat = mq_dat.pop_front();
      sc  = -100;
      if (sq.size() > 0) sc = sq.pop_front();
      lat = mq_cyc.pop_front() - sc;
    end
  endtask

  task automatic expect_out(input string tag, input int ch, input int dat);
    bit ok;
    int c, d, l;
    pop_out(ok, c, d, l);
    chk($sformatf("%s present", tag), ok, 1);
    if (ok) begin
      chk($sformatf("%s ch", tag), c, ch);
      chk($sformatf("%s data", tag), d, dat);
      chk($sformatf("%s latency", tag), l, 2);
    end
  endtask

  initial begin
    // Reset state, asynchronous before any clock edge.
    #1;
    chk("rst m_valid", m_valid, 0);
    chk("rst m_ch", m_ch, 0);
    chk("rst m_data", m_data, 0);
    chk("rst k_err", k_err, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Step response on ch0, k=4, 200 back-to-back samples.
    kwrite(0, 4);
    for (int i = 0; i < 200; i++) drive(1, 0, 1000, 0);
    idle(4);
    prev = 0;
    for (int i = 0; i < 200; i++) begin
      pop_out(o_ok, o_ch, o_dat, o_lat);
      chk($sformatf("t1 present %0d", i), o_ok, 1);
      if (o_ok) begin
        chk($sformatf("t1 ch %0d", i), o_ch, 0);
        chk($sformatf("t1 latency %0d", i), o_lat, 2);
        if (i < 5) chk($sformatf("t1 data %0d", i), o_dat, e0[i]);
        else       chk($sformatf("t1 monotonic %0d", i), (o_dat >= prev), 1);
        prev = o_dat;
      end
    end
    chk("t1 settled", (prev >= 999 && prev <= 1000), 1);
    chk("t1 drained", mq_dat.size(), 0);

    // Negative sample: arithmetic shift and floor.
    do_reset();
    kwrite(1, 4);
    drive(1, 1, -1000, 0);
    idle(3);
    expect_out("t2", 1, -63);

    // Interleaved channels, then ch0 back-to-back.
    do_reset();
    kwrite(0, 4);
    kwrite(1, 4);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1000, 0);
      drive(1, 1, -1000, 0);
    end
    idle(3);
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("t3 il ch0 %0d", i), 0, e0[i]);
      expect_out($sformatf("t3 il ch1 %0d", i), 1, e1[i]);
    end
    do_reset();
    kwrite(0, 4);
    for (int i = 0; i < 5; i++) drive(1, 0, 1000, 0);
    idle(3);
    for (int i = 0; i < 5; i++) expect_out($sformatf("t3 b2b %0d", i), 0, e0[i]);

    // k range boundaries and an illegal write above FRAC_W leaving k=1 in place.
    do_reset();
    kwrite(4, 32);
    chk("t4 k=32 legal", k_err, 0);
    kwrite(4, 1);
    chk("t4 k=1 legal", k_err, 0);
    drive(1, 4, 1000, 0);
    drive(1, 4, 1000, 0);
    kwrite(4, 33);
    chk("t4 k=33 flags", k_err, 1);
    drive(1, 4, 1000, 0);
    idle(3);
    expect_out("t4 k1 s0", 4, 500);
    expect_out("t4 k1 s1", 4, 1000);
    expect_out("t4 k1 after 33", 4, 1000);

    // k=0 / k=40 ignored, then k=8 written at the same edge as a capture.
    do_reset();
    chk("t4 err cleared", k_err, 0);
    kwrite(2, 0);
    chk("t4 k=0 flags", k_err, 1);
    kwrite(2, 40);
    k_wr = 1'b1; k_wr_ch = 3'd2; k_wr_val = 6'd8;
    drive(1, 2, -1000, 0);
    drive(1, 2, -1000, 0);
    idle(3);
    expect_out("t4 old k", 2, -1);
    expect_out("t4 new k", 2, -8);
    chk("t4 err sticky", k_err, 1);

    // Per-sample bypass, state keeps advancing; enable=0 drops samples but takes k writes.
    do_reset();
    kwrite(3, 4);
    drive(1, 3, 1234, 1);
    drive(1, 3, -5, 1);
    drive(1, 3, 0, 0);
    idle(3);
    expect_out("t5 byp0", 3, 1234);
    expect_out("t5 byp1", 3, -5);
    expect_out("t5 after byp", 3, 125);
    enable = 1'b0;
    k_wr = 1'b1; k_wr_ch = 3'd6; k_wr_val = 6'd5;
    drive(1, 3, 1000, 0);
    idle(3);
    chk("t5 disabled no out", mq_dat.size(), 0);
    enable = 1'b1;
    drive(1, 3, 0, 0);
    drive(1, 6, 1000, 0);
    idle(3);
    expect_out("t5 resume ch3", 3, 110);
    expect_out("t5 k while disabled", 6, 31);

    // Reset with samples in flight.
    do_reset();
    kwrite(7, 0);
    chk("t6 err set", k_err, 1);
    kwrite(5, 4);
    drive(1, 5, 1000, 0);
    drive(1, 5, 1000, 0);
    chk("t6 pre m_valid", m_valid, 1);
    chk("t6 pre m_ch", m_ch, 5);
    chk("t6 pre m_data", $signed(m_data), 62);
    #1 reset = 1'b1;
    #1;
    chk("t6 async m_valid", m_valid, 0);
    chk("t6 async m_ch", m_ch, 0);
    chk("t6 async m_data", m_data, 0);
    chk("t6 async k_err", k_err, 0);
    clear_q();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    chk("t6 dropped", mq_dat.size(), 0);
    kwrite(0, 4);
    for (int i = 0; i < 5; i++) drive(1, 0, 1000, 0);
    drive(1, 5, 1000, 0);
    idle(3);
    for (int i = 0; i < 5; i++) expect_out($sformatf("t6 step %0d", i), 0, e0[i]);
    expect_out("t6 ch5 k reset", 5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
